// File: rtl/sipo_frame_ctrl_pkg.sv
// sipo_pkg: shared state encoding and sizing helper for the SIPO framing controller
package sipo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Width of the accepted-bit counter for an n-bit word (never below 1 bit).
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// sipo_frame_ctrl_if: serial input, word output and frame control signals of the framing controller
interface sipo_frame_ctrl_if #(
   parameter int N = 8
);
   import sipo_pkg::*;

   logic                  start;
   logic                  abort;
   logic                  ser_valid;
   logic                  ser_data;
   logic                  ser_ready;
   logic                  word_valid;
   logic                  word_ready;
   logic [N-1:0]          word_data;
   logic [cnt_w(N)-1:0]   bit_count;
   logic                  busy;

   modport master (
      output start, abort, ser_valid, ser_data, word_ready,
      input  ser_ready, word_valid, word_data, bit_count, busy
   );

   modport slave (
      input  start, abort, ser_valid, ser_data, word_ready,
      output ser_ready, word_valid, word_data, bit_count, busy
   );

endinterface

// File: rtl/sipo_frame_ctrl_shift_stage.sv
// sipo_shift_stage: N-bit shift register with enable, serial input and selectable shift direction
module sipo_shift_stage #(
   parameter int N            = 8,
   parameter bit FIRST_AT_MSB = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic         d_i,
   output logic [N-1:0] q_o
);

   logic [N-1:0] data_q, data_d;

   // New bit enters at the LSB end when the first bit must finish at the MSB, and vice versa.
   always_comb data_d = FIRST_AT_MSB ? {data_q[N-2:0], d_i} : {d_i, data_q[N-1:1]};

   // Contents change only on an enabled shift; cleared by reset.
   always_ff @(posedge clk or negedge reset)
      if (!reset) data_q <= '0;
      else if (en_i) data_q <= data_d;

   assign q_o = data_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: counts N accepted serial bits into a word and hands it off over valid/ready
module sipo_frame_ctrl
   import sipo_pkg::*;
#(
   parameter int N            = 8,
   parameter bit FIRST_AT_MSB = 1'b1,
   parameter bit CONTINUOUS   = 1'b0
) (
   input logic              clk,
   input logic              reset,
   sipo_frame_ctrl_if.slave bus
);

   localparam int CW = cnt_w(N);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept;
   logic          last_bit;
   logic [N-1:0]  word;

   // abort is the only combinational input path to ser_ready; everything else comes from state.
   assign bus.ser_ready  = (state_q == SHIFT) && !bus.abort;
   assign bus.word_valid = (state_q == HOLD);
   assign bus.busy       = (state_q != IDLE);
   assign bus.bit_count  = cnt_q;
   assign bus.word_data  = word;

   assign accept   = bus.ser_valid && bus.ser_ready;
   assign last_bit = (cnt_q == CW'(N - 1));

   sipo_shift_stage #(
      .N            (N),
      .FIRST_AT_MSB (FIRST_AT_MSB)
   ) u_shift (
      .clk   (clk),
      .reset (reset),
      .en_i  (accept),
      .d_i   (bus.ser_data),
      .q_o   (word)
   );

   // State and bit counter registers.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end

   // Next state and count; abort overrides start, bit acceptance and handoff.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (bus.abort) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (bus.start) state_d = SHIFT;
            end
            SHIFT:
               if (accept) begin
                  cnt_d = last_bit ? '0 : cnt_q + 1'b1;
                  if (last_bit) state_d = HOLD;
               end
            HOLD:
               if (bus.word_ready) state_d = CONTINUOUS ? SHIFT : IDLE;
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: scoreboard bench for MSB-first, LSB-first and continuous framing variants
module tb_sipo_frame_ctrl;

   logic clk = 1'b0;
   logic rst_n, start, abort, ser_valid, ser_data, word_ready;
   int   errors = 0;
   int   checks = 0;
   logic [7:0] qa[$], qb[$], qc[$];

   always #5 clk = ~clk;

   sipo_frame_ctrl_if #(.N(8)) ia ();
   sipo_frame_ctrl_if #(.N(8)) ib ();
   sipo_frame_ctrl_if #(.N(8)) ic ();

   assign {ia.start, ia.abort, ia.ser_valid, ia.ser_data, ia.word_ready} = {start, abort, ser_valid, ser_data, word_ready};
   assign {ib.start, ib.abort, ib.ser_valid, ib.ser_data, ib.word_ready} = {start, abort, ser_valid, ser_data, word_ready};
   assign {ic.start, ic.abort, ic.ser_valid, ic.ser_data, ic.word_ready} = {start, abort, ser_valid, ser_data, word_ready};

   sipo_frame_ctrl #(.N(8), .FIRST_AT_MSB(1'b1), .CONTINUOUS(1'b0)) dut_a (.clk(clk), .reset(rst_n), .bus(ia));
   sipo_frame_ctrl #(.N(8), .FIRST_AT_MSB(1'b0), .CONTINUOUS(1'b0)) dut_b (.clk(clk), .reset(rst_n), .bus(ib));
   sipo_frame_ctrl #(.N(8), .FIRST_AT_MSB(1'b1), .CONTINUOUS(1'b1)) dut_c (.clk(clk), .reset(rst_n), .bus(ic));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Stream value s is sent s[7] first; the LSB-first variant places bit i of the stream at word bit i.
   function automatic logic [7:0] rev(input logic [7:0] s);
      for (int i = 0; i < 8; i++) rev[i] = s[7-i];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] s, input bit only_c);
      if (!only_c) begin
         qa.push_back(s);
         qb.push_back(rev(s));
      end
      qc.push_back(s);
   endtask

   task automatic send_bits(input logic [7:0] s, input bit gap);
      for (int i = 0; i < 8; i++) begin
         ser_valid = 1'b1;
         ser_data  = s[7-i];
         tick;
         ser_valid = 1'b0;
         if (i < 7) chk("cnt", 64'(ic.bit_count), 64'(i + 1));
         if (gap && i < 7) begin
            tick;
            chk("gap_cnt", 64'(ic.bit_count), 64'(i + 1));
            chk("gap_nv", 64'(ic.word_valid), 64'd0);
         end
      end
      chk("frame_cnt0", 64'(ic.bit_count), 64'd0);
   endtask

   task automatic abort_pulse;
      abort = 1'b1;
      #1;
      chk("abort_rdy", 64'(ic.ser_ready), 64'd0);
      tick;
      abort = 1'b0;
      chk("abort_idle", 64'(ic.busy), 64'd0);
   endtask

   // Scoreboards: every handshake that actually completes must match the oldest expected word.
   always @(negedge clk)
      if (rst_n && ia.word_valid && word_ready && !abort) begin
         if (qa.size() == 0) chk("a_unexp", 64'(qa.size()), 64'd1);
         else chk("a_word", 64'(ia.word_data), 64'(qa.pop_front()));
      end

   always @(negedge clk)
      if (rst_n && ib.word_valid && word_ready && !abort) begin
         if (qb.size() == 0) chk("b_unexp", 64'(qb.size()), 64'd1);
         else chk("b_word", 64'(ib.word_data), 64'(qb.pop_front()));
      end

   always @(negedge clk)
      if (rst_n && ic.word_valid && word_ready && !abort) begin
         if (qc.size() == 0) chk("c_unexp", 64'(qc.size()), 64'd1);
         else chk("c_word", 64'(ic.word_data), 64'(qc.pop_front()));
      end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] g;
      {start, abort, ser_valid, ser_data, word_ready} = '0;
      rst_n = 1'b0;
      repeat (2) tick;
      chk("rst_rdy", 64'(ia.ser_ready), 64'd0);
      chk("rst_valid", 64'(ia.word_valid), 64'd0);
      chk("rst_data", 64'(ia.word_data), 64'd0);
      chk("rst_cnt", 64'(ia.bit_count), 64'd0);
      chk("rst_busy", 64'(ia.busy), 64'd0);
      rst_n = 1'b1;
      tick;
      chk("idle_rdy", 64'(ia.ser_ready), 64'd0);

      // basic frame, all three variants
      word_ready = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("start_rdy", 64'(ia.ser_ready), 64'd1);
      chk("start_busy", 64'(ia.busy), 64'd1);
      push(8'hB2, 1'b0);
      send_bits(8'hB2, 1'b0);
      chk("a_valid", 64'(ia.word_valid), 64'd1);
      chk("a_hold_rdy", 64'(ia.ser_ready), 64'd0);
      chk("a_b2", 64'(ia.word_data), 64'hB2);
      chk("b_4d", 64'(ib.word_data), 64'h4D);
      tick;
      chk("a_done", 64'(ia.busy), 64'd0);
      chk("b_done", 64'(ib.busy), 64'd0);
      chk("c_cont_rdy", 64'(ic.ser_ready), 64'd1);
      abort_pulse;

      // gapped input
      g = 8'($urandom_range(255));
      start = 1'b1;
      tick;
      start = 1'b0;
      push(g, 1'b0);
      send_bits(g, 1'b1);
      chk("gap_valid", 64'(ia.word_valid), 64'd1);
      tick;
      abort_pulse;

      // back-pressure with a second frame offered during HOLD
      word_ready = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      push(8'hC3, 1'b0);
      send_bits(8'hC3, 1'b0);
      ser_valid = 1'b1;
      ser_data  = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick;
         chk("bp_rdy", 64'(ic.ser_ready), 64'd0);
         chk("bp_valid", 64'(ic.word_valid), 64'd1);
         chk("bp_data", 64'(ic.word_data), 64'hC3);
      end
      word_ready = 1'b1;
      tick;
      chk("bp_next_rdy", 64'(ic.ser_ready), 64'd1);
      chk("bp_a_idle", 64'(ia.busy), 64'd0);
      push(8'h5A, 1'b1);
      send_bits(8'h5A, 1'b0);
      chk("c_5a", 64'(ic.word_data), 64'h5A);
      tick;
      abort_pulse;

      // abort mid-frame, then a clean frame
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ser_valid = 1'b1;
         ser_data  = 1'b1;
         tick;
      end
      chk("pre_abort_cnt", 64'(ia.bit_count), 64'd3);
      abort = 1'b1;
      #1;
      chk("abort_comb_rdy", 64'(ia.ser_ready), 64'd0);
      tick;
      abort = 1'b0;
      ser_valid = 1'b0;
      chk("abort_cnt", 64'(ia.bit_count), 64'd0);
      chk("abort_busy", 64'(ia.busy), 64'd0);
      chk("abort_valid", 64'(ia.word_valid), 64'd0);
      start = 1'b1;
      abort = 1'b1;
      tick;
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_idle", 64'(ia.busy), 64'd0);
      start = 1'b1;
      tick;
      start = 1'b0;
      push(8'h96, 1'b0);
      send_bits(8'h96, 1'b0);
      chk("a_96", 64'(ia.word_data), 64'h96);
      tick;
      abort_pulse;

      // asynchronous reset while holding a word
      word_ready = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      send_bits(8'hE7, 1'b0);
      chk("pre_rst_valid", 64'(ia.word_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(ia.word_valid), 64'd0);
      chk("arst_data", 64'(ia.word_data), 64'd0);
      chk("arst_busy", 64'(ia.busy), 64'd0);
      chk("arst_c_data", 64'(ic.word_data), 64'd0);
      word_ready = 1'b1;
      tick;
      rst_n = 1'b1;
      tick;
      chk("post_rst_valid", 64'(ia.word_valid), 64'd0);
      chk("post_rst_busy", 64'(ic.busy), 64'd0);

      chk("qa_empty", 64'(qa.size()), 64'd0);
      chk("qb_empty", 64'(qb.size()), 64'd0);
      chk("qc_empty", 64'(qc.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Framing controller for a serial-in/parallel-out shift path. It accepts a qualified serial bit stream, counts exactly N accepted bits into an internal shift stage, and presents the assembled word on a valid/ready output. It back-pressures the serial side while a word is waiting. It sits between a serial line front-end (pin synchroniser or bit-slicer) and any word-wide consumer such as a FIFO or register file.

## Interface
- N, default 8: word width in bits; legal range 2..64.
- FIRST_AT_MSB, default 1: 1 = shift toward MSB, so the first bit ends in word_data[N-1]; 0 = shift toward LSB, so the first bit ends in word_data[0].
- CONTINUOUS, default 0: 1 = after a word handoff, re-enter SHIFT without a new start.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin capture of one frame; honoured only in IDLE.
- abort  in  1  synchronous discard of the current frame; returns to IDLE.
- ser_valid  in  1  ser_data is valid this cycle.
- ser_data  in  1  serial bit.
- ser_ready  out  1  a bit is accepted this cycle when ser_valid && ser_ready.
- word_valid  out  1  word_data holds a complete frame.
- word_ready  in  1  consumer accepts the word when word_valid && word_ready.
- word_data  out  N  assembled word.
- bit_count  out  $clog2(N)  number of bits accepted in the current frame.
- busy  out  1  high in SHIFT or HOLD.

## Operation
- States: IDLE, SHIFT, HOLD; the encoding is a 2-bit enum.
- IDLE:
  - ser_ready=0, word_valid=0, bit_count=0.
  - start=1 moves to SHIFT and clears the count.
- SHIFT:
  - ser_ready=1 and word_valid=0.
  - Each accepted bit shifts into the shift stage and increments bit_count.
  - Acceptance of bit N-1 (count N-1 → wrap to 0) moves to HOLD.
  - Cycles without ser_valid are idle; no state changes.
- HOLD:
  - ser_ready=0 and word_valid=1; word_data is frozen.
  - On handoff: go to SHIFT if CONTINUOUS=1, otherwise to IDLE.
  - The shift stage is not cleared on handoff; the next frame fully overwrites it.
- abort:
  - From SHIFT or HOLD, go to IDLE and set bit_count=0. Any partial or held word is dropped.
  - abort has priority over start, bit acceptance and handoff in the same cycle.
  - A bit offered in the abort cycle is not accepted; ser_ready is forced to 0 combinationally while abort=1.
- start in SHIFT or HOLD is ignored.
- start and abort together in IDLE: stay in IDLE.
- busy = (state != IDLE).

## Timing
- Reset values: state=IDLE, ser_ready=0, word_valid=0, word_data=0, bit_count=0, busy=0.
- Reset mid-frame discards everything immediately, with no handoff.
- ser_ready and word_valid are decoded from the registered state. The only combinational input path is abort → ser_ready.
- Bit latency: a bit accepted at edge t is visible in word_data after edge t.
- Frame latency:
  - start sampled at edge t0 makes ser_ready=1 from t0+1.
  - N back-to-back bits make word_valid=1 the cycle after the Nth acceptance.
  - Minimum start-to-word_valid is N+1 cycles.
- Handoff at edge th:
  - CONTINUOUS=1: ser_ready=1 in cycle th+1, so the gap between frames is 1 cycle.
  - CONTINUOUS=0: a new start is needed.
- word_data changes only on an accepted bit; it is stable throughout HOLD regardless of ser_valid.

## Structure
- The shared package sipo_pkg holds:
  - the state enum typedef (IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2);
  - a function computing the count width.
- One sub-module, sipo_shift_stage:
  - N-bit register with shift enable, serial in, and a direction parameter;
  - asynchronous active-low clear on reset;
  - parallel out.
- The controller instantiates one sipo_shift_stage, with shift enable = ser_valid && ser_ready.
- The FSM and counter live in sipo_frame_ctrl.

## Test plan
- Reset and basic frame, with N=8, FIRST_AT_MSB=1:
  - Stimulus: reset low then high, start, then bits 1,0,1,1,0,0,1,0 back-to-back.
  - Response: word_valid=1 one cycle after the last bit, word_data=8'hB2. With word_ready=1: IDLE next cycle, busy=0.
- LSB variant, FIRST_AT_MSB=0:
  - Stimulus: the same bit stream.
  - Response: word_data=8'h4D.
- Gapped input:
  - Stimulus: ser_valid toggles 1,0,1,0,… across 8 bits.
  - Response: bit_count advances only on valid cycles, and word_valid is asserted after the 8th valid.
- Back-pressure, CONTINUOUS=1:
  - Stimulus: word_ready held 0 for 5 cycles while ser_valid=1.
  - Response: ser_ready=0, word_data stable for 5 cycles, no bits lost. After the handoff, ser_ready=1 next cycle and the second frame 8'h5A is captured correctly.
- Abort:
  - Stimulus: abort after 3 bits, then start with 8 new bits.
  - Response: bit_count=0 after abort, no word_valid, and the new word matches only the new 8 bits.
- Async reset mid-HOLD:
  - Stimulus: reset pulsed low while word_valid=1.
  - Response: word_valid, word_data and busy drop to 0 immediately, and no handoff occurs.
